// File: rtl/key_cond_pkg.sv
// Shared types and constants for the Tug of War key conditioners.
package key_cond_pkg;

    // Debounce FSM: two stable states, each with a qualifying state in front of the opposite one
    typedef enum logic [1:0] {
        UP     = 2'd0,
        DN_CHK = 2'd1,
        DOWN   = 2'd2,
        UP_CHK = 2'd3
    } key_state_e;

    // Simulation-friendly default; the board top overrides with roughly 1 ms of clock cycles
    localparam int KEY_DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/key_conditioner_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; also used for the second player's key.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    // Two-stage resynchronization into the clk domain; both stages clear on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronizes an active-low key, debounces it, and produces
// a clean active-high level plus a one-cycle press pulse.
// Build option: KEY_COND_DEBOUNCE_EN enables the debounce FSM/counter; when undefined
// the synchronized key is passed straight to level with a rising-edge pulse.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic pulse
);

    // The counter compare against DEBOUNCE_CYCLES-1 only makes sense for two or more samples
    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    logic w_s2;
    logic r_level;
    logic r_pulse;

    // Invert at the pin so everything downstream is active-high "pressed"
    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (~key_n),
        .q     (w_s2)
    );

`ifdef KEY_COND_DEBOUNCE_EN
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    key_state_e    r_state;
    logic [CW-1:0] r_cnt;

    // Debounce FSM; level tracks the next state and the pulse fires only on a qualified press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= UP;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                UP: begin
                    r_level <= 1'b0;
                    if (w_s2) begin
                        r_state <= DN_CHK;
                        r_cnt   <= CW'(1);
                    end
                end
                DN_CHK: begin
                    r_level <= 1'b0;
                    if (!w_s2) begin
                        // bounce: press did not stay stable long enough
                        r_state <= UP;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= DOWN;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DOWN: begin
                    r_level <= 1'b1;
                    if (!w_s2) begin
                        r_state <= UP_CHK;
                        r_cnt   <= CW'(1);
                    end
                end
                UP_CHK: begin
                    r_level <= 1'b1;
                    if (w_s2) begin
                        // release bounce: return to held without a new pulse
                        r_state <= DOWN;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= UP;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= UP;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end
`else
    // Pass-through: level follows the synchronized key, pulse marks its rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_level <= w_s2;
            r_pulse <= w_s2 & ~r_level;
        end
    end
`endif

    assign level = r_level;
    assign pulse = r_pulse;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with DEBOUNCE_CYCLES=4; follows the KEY_COND_DEBOUNCE_EN build option.
module tb_key_conditioner;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic key_n = 1'b1;
    logic level;
    logic pulse;

    key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .level (level),
        .pulse (pulse)
    );

    always #5 clk = ~clk;

`ifdef KEY_COND_DEBOUNCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic  k;
        logic  lv;
        logic  pl;
        string nm;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
    endtask

    task automatic addn(input string nm, input logic k, input logic lv, input logic pl, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.k  = k;
            v.lv = lv;
            v.pl = pl;
            v.nm = nm;
            tbl.push_back(v);
        end
    endtask

    // Drive key for one edge, then sample 1 time unit after it
    task automatic step(input logic k);
        key_n = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef KEY_COND_DEBOUNCE_EN
        addn("idle",     1, 0, 0, 10);
        // held press: level/pulse rise after edge 5
        addn("press",    0, 0, 0, 5);
        addn("press",    0, 1, 1, 1);
        addn("press",    0, 1, 0, 4);
        // release bounce of 2 samples: stays held
        addn("relbnc",   1, 1, 0, 2);
        addn("relbnc",   0, 1, 0, 4);
        // real release: level falls after edge 5
        addn("release",  1, 1, 0, 5);
        addn("release",  1, 0, 0, 2);
        // 3-cycle glitch rejected
        addn("glitch3",  0, 0, 0, 3);
        addn("glitch3",  1, 0, 0, 5);
        // 4-cycle press accepted, then released
        addn("press4",   0, 0, 0, 4);
        addn("press4",   1, 0, 0, 1);
        addn("press4",   1, 1, 1, 1);
        addn("press4",   1, 1, 0, 3);
        addn("press4",   1, 0, 0, 3);
`else
        addn("idle",     1, 0, 0, 5);
        // one-cycle glitch propagates as one cycle after edge 2
        addn("glitch1",  0, 0, 0, 1);
        addn("glitch1",  1, 0, 0, 1);
        addn("glitch1",  1, 1, 1, 1);
        addn("glitch1",  1, 0, 0, 2);
        addn("held",     0, 0, 0, 2);
        addn("held",     0, 1, 1, 1);
        addn("held",     0, 1, 0, 3);
        addn("release",  1, 1, 0, 2);
        addn("release",  1, 0, 0, 2);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 0, level, 1'b0);
        check("rst_pulse", 0, pulse, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].k);
            check({tbl[i].nm, "_level"}, i, level, tbl[i].lv);
            check({tbl[i].nm, "_pulse"}, i, pulse, tbl[i].pl);
        end

        // Async reset mid-cycle (first while held, then mid-qualification), key kept low across it
        for (int r = 0; r < 2; r++) begin
            int pre;
            pre = (r == 0) ? LAT + 2 : 3;
            for (int j = 0; j < pre; j++) step(1'b0);
            if (r == 0) check("held_before_rst", r, level, 1'b1);
            #2 reset = 1'b1;
            #1;
            check("async_rst_level", r, level, 1'b0);
            check("async_rst_pulse", r, pulse, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step(1'b0);
                check("post_rst_level", i, level, (i >= LAT) ? 1'b1 : 1'b0);
                check("post_rst_pulse", i, pulse, (i == LAT) ? 1'b1 : 1'b0);
            end
            for (int j = 0; j < LAT + 2; j++) step(1'b1);
            check("post_rst_released", r, level, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioner for one active-low pushbutton in the Tug of War design. It synchronizes the raw key into the clock domain and debounces it. It produces a clean active-high level and a single-cycle press pulse. It sits directly upstream of the player-input FSM and drives that FSM's `w` input, or the pulse input of the scoring logic.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required to change the debounced level. Legal values are ≥ 2.
- `clk`: input, 1 bit, system clock.
- `reset`: input, 1 bit. Asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `key_n`: input, 1 bit. Raw, asynchronous pushbutton, 0 = pressed.
- `level`: output, 1 bit. Debounced key state, 1 = pressed. Registered.
- `pulse`: output, 1 bit. High for exactly one cycle per debounced press. Registered.

## Operation
- Synchronizer: two flops, `s1 <= ~key_n` then `s2 <= s1`. `s2` is the synchronized pressed signal.
- FSM states:
  - `UP`: level 0.
  - `DN_CHK`: level 0, counting.
  - `DOWN`: level 1.
  - `UP_CHK`: level 1, counting.
- Counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide, unsigned. It never wraps; it is cleared on every state exit.
- `UP`: if `s2`=1, go to `DN_CHK` with `cnt`=1. Otherwise stay.
- `DN_CHK`:
  - If `s2`=0, go to `UP` with `cnt`=0 (a bounce is rejected).
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1, go to `DOWN` and set `pulse`.
  - Else `cnt`++.
- `DOWN`: if `s2`=0, go to `UP_CHK` with `cnt`=1. Otherwise stay.
- `UP_CHK`:
  - If `s2`=1, go to `DOWN` with `cnt`=0. No pulse.
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1, go to `UP`.
  - Else `cnt`++.
- `level` is registered: 1 iff the next state is `DOWN` or `UP_CHK`.
- `pulse` is registered: 1 only in the cycle following the `DN_CHK`→`DOWN` transition. A release never pulses.
- Unreachable state encodings go to `UP` at the next edge.

## Timing
- Reset values: `s1`=`s2`=0, state `UP`, `cnt`=0, `level`=0, `pulse`=0.
  - Reset asserts asynchronously and forces the outputs low without waiting for a clock edge.
- Edge 0 is the first rising edge that samples `key_n`=0. `s2`=1 after edge 1.
- `level` and `pulse` rise immediately after edge `DEBOUNCE_CYCLES`+1 (edge 5 at default). `pulse` falls after the next edge.
- Release latency is symmetric: `level` falls `DEBOUNCE_CYCLES`+1 edges after `key_n`=1 is first sampled.
- A press must be sampled low for at least `DEBOUNCE_CYCLES` consecutive `s2` samples. Shorter glitches cause no output change.
- A key held across reset deassertion is treated as a new press: full latency, one pulse.
- At most one pulse per press; the minimum pulse spacing is 2·`DEBOUNCE_CYCLES` cycles.

## Configuration
- `KEY_COND_DEBOUNCE_EN`
  - Defined: behaves as described above.
  - Undefined: the FSM and counter are removed.
    - `level <= s2` on every edge.
    - `pulse <= s2 & ~level`.
    - `level` and `pulse` rise after edge 2. Glitches propagate with matching width.
    - Reset values are unchanged.

## Structure
- `key_cond_pkg` holds:
  - the state enum typedef (`UP`, `DN_CHK`, `DOWN`, `UP_CHK`);
  - the constant `KEY_DEBOUNCE_DEFAULT` = 4, shared with the top level. The top uses a larger value for the board, near 1 ms of clock cycles.
- One sub-module, `sync2`: a two-flop synchronizer with `clk`, async `reset` (clears to 0), `d` and `q`. It is reused for the second player's key.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 with `KEY_COND_DEBOUNCE_EN` defined, except the last.
- Reset with `key_n`=1, then 10 cycles idle → `level`=0 and `pulse`=0 throughout.
- `key_n`=0 held for 10 cycles → `level` rises after edge 5 and stays 1. `pulse`=1 for exactly one cycle, aligned with the `level` rise.
- `key_n`=0 for 3 cycles, then 1 → `level` and `pulse` stay 0. Repeating with 4 cycles low → one pulse.
- From held, `key_n`=1 for 2 cycles then 0 → `level` stays 1 with no pulse. Then `key_n`=1 for 4+ cycles → `level` falls 5 edges after first sampling, with no pulse.
- `reset` asserted mid-`DN_CHK`, between edges → `level`=0 and `pulse`=0 immediately. Deassert with the key still low → a single pulse 5 edges after the first post-reset sample.
- `KEY_COND_DEBOUNCE_EN` undefined, 1-cycle `key_n` low glitch → `level`=1 for one cycle after edge 2, with a matching one-cycle `pulse`.
